// File: rtl/cpu_pkg.sv
// Shared constants and port-slicing helpers for the register file and its
// write arbiter.
package cpu_pkg;

    localparam int REGSIZE_DEF = 5;
    localparam int DIGIT_DEF   = 32;
    localparam int ZERO_REG    = 0;

    // Packed port vectors place port p at bits [p*width +: width].
    function automatic int portLsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// Resolves which write port (if any) targets one address this cycle.
// A higher port index wins over lower ones.
module regfile_write_arbiter
    import cpu_pkg::*;
#(
    parameter int REGSIZE     = REGSIZE_DEF,
    parameter int DIGIT       = DIGIT_DEF,
    parameter int WRITE_PORTS = 2
) (
    input  logic [REGSIZE-1:0]             lookupAddress_i,
    input  logic [WRITE_PORTS-1:0]         writeEnable_i,
    input  logic [WRITE_PORTS*REGSIZE-1:0] writeAddress_i,
    input  logic [WRITE_PORTS*DIGIT-1:0]   writeData_i,
    output logic                           hit_o,
    output logic [DIGIT-1:0]               data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (writeEnable_i[w] &&
                writeAddress_i[portLsb(w, REGSIZE) +: REGSIZE] == lookupAddress_i) begin
                hit_o  = 1'b1;
                data_o = writeData_i[portLsb(w, DIGIT) +: DIGIT];
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-to-read bypass and a per-register
// pending scoreboard used by issue logic to stall on RAW/WAW hazards.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int REGSIZE     = REGSIZE_DEF,
    parameter int DIGIT       = DIGIT_DEF,
    parameter int READ_PORTS  = 3,
    parameter int WRITE_PORTS = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [READ_PORTS*REGSIZE-1:0]  Read_Address,
    output logic [READ_PORTS*DIGIT-1:0]    Read_Data,
    output logic [READ_PORTS-1:0]          Read_Ready,
    input  logic [WRITE_PORTS-1:0]         Write_Enable,
    input  logic [WRITE_PORTS*REGSIZE-1:0] Write_Address,
    input  logic [WRITE_PORTS*DIGIT-1:0]   Write_Data,
    input  logic                           Issue_Enable,
    input  logic [REGSIZE-1:0]             Issue_Address,
    output logic                           Issue_Accept,
    output logic [REGSIZE:0]               Pending_Count
);

    localparam int DEPTH = 2 ** REGSIZE;

    logic [DIGIT-1:0]   regs_q [DEPTH];
    logic [DIGIT-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]   pending_q, pending_d;
    logic [REGSIZE:0]   count_q, count_d;
    logic [REGSIZE:0]   setCount, clrCount;
    logic [DEPTH-1:0]   regWriteHit;
    logic [DIGIT-1:0]   regWriteData [DEPTH];
    logic               issueZero;
    logic               issueAccept;

    // One arbiter per register gives the effective write for storage and pending clear.
    for (genvar r = 0; r < DEPTH; r++) begin : gRegLookup
        regfile_write_arbiter #(
            .REGSIZE     (REGSIZE),
            .DIGIT       (DIGIT),
            .WRITE_PORTS (WRITE_PORTS)
        ) uArb (
            .lookupAddress_i (REGSIZE'(r)),
            .writeEnable_i   (Write_Enable),
            .writeAddress_i  (Write_Address),
            .writeData_i     (Write_Data),
            .hit_o           (regWriteHit[r]),
            .data_o          (regWriteData[r])
        );
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : gReadPort
        logic [REGSIZE-1:0] rdAddr;
        logic               rdHit;
        logic               rdZero;
        logic [DIGIT-1:0]   rdBypass;

        assign rdAddr = Read_Address[portLsb(p, REGSIZE) +: REGSIZE];
        assign rdZero = (rdAddr == REGSIZE'(ZERO_REG));

        regfile_write_arbiter #(
            .REGSIZE     (REGSIZE),
            .DIGIT       (DIGIT),
            .WRITE_PORTS (WRITE_PORTS)
        ) uArb (
            .lookupAddress_i (rdAddr),
            .writeEnable_i   (Write_Enable),
            .writeAddress_i  (Write_Address),
            .writeData_i     (Write_Data),
            .hit_o           (rdHit),
            .data_o          (rdBypass)
        );

        assign Read_Data[portLsb(p, DIGIT) +: DIGIT] =
            rdZero ? '0 : (rdHit ? rdBypass : regs_q[rdAddr]);
        assign Read_Ready[p] = rdZero || !pending_q[rdAddr] || rdHit;
    end

    // A pending destination can still be reissued if its producer writes back now.
    assign issueZero   = (Issue_Address == REGSIZE'(ZERO_REG));
    assign issueAccept = Issue_Enable &&
                         (issueZero || !pending_q[Issue_Address] || regWriteHit[Issue_Address]);
    assign Issue_Accept  = issueAccept;
    assign Pending_Count = count_q;

    // An accepted issue outranks a same-cycle writeback for the pending bit.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (r != ZERO_REG) begin
                if (regWriteHit[r]) begin
                    regs_d[r] = regWriteData[r];
                end
                if (issueAccept && Issue_Address == REGSIZE'(r)) begin
                    pending_d[r] = 1'b1;
                end else if (regWriteHit[r]) begin
                    pending_d[r] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        setCount = '0;
        clrCount = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (pending_d[r] && !pending_q[r]) begin
                setCount = setCount + (REGSIZE+1)'(1);
            end else if (!pending_d[r] && pending_q[r]) begin
                clrCount = clrCount + (REGSIZE+1)'(1);
            end
        end
        count_d = count_q + setCount - clrCount;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a monitor
// compares them against the DUT at the falling edge.
module tb_regfile_scoreboard;

    localparam int SEL_READY  = 3;
    localparam int SEL_ACCEPT = 4;
    localparam int SEL_COUNT  = 5;

    typedef struct {
        int          cycle;
        int          sel;
        logic [31:0] value;
        string       name;
    } ExpT;

    logic        clock;
    logic        reset;
    logic [14:0] readAddress;
    logic [95:0] readData;
    logic [2:0]  readReady;
    logic [1:0]  writeEnable;
    logic [9:0]  writeAddress;
    logic [63:0] writeData;
    logic        issueEnable;
    logic [4:0]  issueAddress;
    logic        issueAccept;
    logic [5:0]  pendingCount;

    ExpT sbQueue[$];
    int  cycleNum  = 0;
    int  testsRun  = 0;
    int  failCount = 0;

    regfile_scoreboard #(
        .REGSIZE     (5),
        .DIGIT       (32),
        .READ_PORTS  (3),
        .WRITE_PORTS (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .Read_Address  (readAddress),
        .Read_Data     (readData),
        .Read_Ready    (readReady),
        .Write_Enable  (writeEnable),
        .Write_Address (writeAddress),
        .Write_Data    (writeData),
        .Issue_Enable  (issueEnable),
        .Issue_Address (issueAddress),
        .Issue_Accept  (issueAccept),
        .Pending_Count (pendingCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleNum <= cycleNum + 1;

    task automatic applyStimulus(
        input logic        rst,
        input logic [4:0]  ra0, input logic [4:0] ra1, input logic [4:0] ra2,
        input logic [1:0]  we,
        input logic [4:0]  wa0, input logic [31:0] wd0,
        input logic [4:0]  wa1, input logic [31:0] wd1,
        input logic        ie,  input logic [4:0] ia);
        @(posedge clock);
        #1;
        reset        = rst;
        readAddress  = {ra2, ra1, ra0};
        writeEnable  = we;
        writeAddress = {wa1, wa0};
        writeData    = {wd1, wd0};
        issueEnable  = ie;
        issueAddress = ia;
    endtask

    task automatic expectOut(input int sel, input logic [31:0] value, input string name);
        ExpT e;
        e.cycle = cycleNum;
        e.sel   = sel;
        e.value = value;
        e.name  = name;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input ExpT e);
        logic [31:0] actual;
        case (e.sel)
            0, 1, 2:    actual = readData[e.sel*32 +: 32];
            SEL_READY:  actual = 32'(readReady);
            SEL_ACCEPT: actual = 32'(issueAccept);
            default:    actual = 32'(pendingCount);
        endcase
        testsRun++;
        if (actual !== e.value) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", e.name, actual, e.value, e.cycle);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (sbQueue.size() > 0 && sbQueue[0].cycle <= cycleNum) begin
                ExpT e;
                e = sbQueue.pop_front();
                if (e.cycle < cycleNum) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL %s: stale entry, got no sample, expected one in cycle %0d", e.name, e.cycle);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        readAddress  = '0;
        writeEnable  = '0;
        writeAddress = '0;
        writeData    = '0;
        issueEnable  = 1'b0;
        issueAddress = '0;

        applyStimulus(0, 0, 5, 31, 2'b00, 0, 0, 0, 0, 0, 0);
        expectOut(0, 32'h0, "rst_data0");
        expectOut(1, 32'h0, "rst_data5");
        expectOut(2, 32'h0, "rst_data31");
        expectOut(SEL_READY, 32'h7, "rst_ready");
        expectOut(SEL_COUNT, 32'h0, "rst_count");

        applyStimulus(0, 0, 7, 7, 2'b01, 7, 32'hDEADBEEF, 0, 0, 0, 0);
        expectOut(1, 32'hDEADBEEF, "bypass_p1");
        expectOut(2, 32'hDEADBEEF, "bypass_p2");
        expectOut(SEL_READY, 32'h7, "bypass_ready");

        applyStimulus(0, 0, 7, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expectOut(1, 32'hDEADBEEF, "stored_7");

        applyStimulus(0, 9, 0, 0, 2'b11, 9, 32'h1111, 9, 32'h2222, 0, 0);
        expectOut(0, 32'h2222, "prio_bypass_9");

        applyStimulus(0, 9, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expectOut(0, 32'h2222, "prio_stored_9");

        applyStimulus(0, 0, 0, 0, 2'b10, 0, 0, 0, 32'hFFFF, 0, 0);
        expectOut(0, 32'h0, "zero_write_bypass");

        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expectOut(0, 32'h0, "zero_write_stored");

        applyStimulus(0, 3, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3);
        expectOut(SEL_ACCEPT, 32'h1, "issue3_accept");
        expectOut(SEL_READY, 32'h7, "issue3_ready_same");
        expectOut(SEL_COUNT, 32'h0, "issue3_count_same");

        applyStimulus(0, 3, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3);
        expectOut(SEL_READY, 32'h6, "raw3_ready");
        expectOut(SEL_ACCEPT, 32'h0, "waw3_accept");
        expectOut(SEL_COUNT, 32'h1, "issue3_count");

        applyStimulus(0, 3, 0, 0, 2'b01, 3, 32'h42, 0, 0, 0, 0);
        expectOut(SEL_READY, 32'h7, "wb3_ready");
        expectOut(0, 32'h42, "wb3_data");
        expectOut(SEL_COUNT, 32'h1, "wb3_count_same");

        applyStimulus(0, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expectOut(SEL_READY, 32'h7, "wb3_ready_next");
        expectOut(0, 32'h42, "wb3_data_next");
        expectOut(SEL_COUNT, 32'h0, "wb3_count_next");

        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4);
        expectOut(SEL_ACCEPT, 32'h1, "issue4_accept");

        applyStimulus(0, 4, 0, 0, 2'b10, 0, 0, 4, 32'h77, 1, 4);
        expectOut(SEL_ACCEPT, 32'h1, "reissue4_accept");
        expectOut(SEL_COUNT, 32'h1, "reissue4_count");
        expectOut(SEL_READY, 32'h7, "reissue4_ready");
        expectOut(0, 32'h77, "reissue4_data");

        applyStimulus(0, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expectOut(SEL_READY, 32'h6, "still_pending4");
        expectOut(SEL_COUNT, 32'h1, "net_zero_count");
        expectOut(0, 32'h77, "stored4");

        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        expectOut(SEL_ACCEPT, 32'h1, "issue1_accept");

        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2);
        expectOut(SEL_ACCEPT, 32'h1, "issue2_accept");
        expectOut(SEL_COUNT, 32'h2, "issue1_count");

        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        expectOut(SEL_ACCEPT, 32'h1, "issue0_accept");
        expectOut(SEL_COUNT, 32'h3, "issue2_count");

        applyStimulus(1, 1, 2, 4, 2'b01, 1, 32'h5, 0, 0, 0, 0);
        expectOut(SEL_COUNT, 32'h3, "issue0_no_count");
        expectOut(SEL_READY, 32'h1, "pre_reset_ready");
        expectOut(0, 32'h5, "pre_reset_bypass");

        applyStimulus(0, 1, 2, 4, 2'b00, 0, 0, 0, 0, 0, 0);
        expectOut(0, 32'h0, "post_reset_data1");
        expectOut(2, 32'h0, "post_reset_data4");
        expectOut(SEL_READY, 32'h7, "post_reset_ready");
        expectOut(SEL_COUNT, 32'h0, "post_reset_count");

        applyStimulus(0, 7, 9, 3, 2'b00, 0, 0, 0, 0, 1, 0);
        expectOut(0, 32'h0, "post_reset_data7");
        expectOut(1, 32'h0, "post_reset_data9");
        expectOut(2, 32'h0, "post_reset_data3");
        expectOut(SEL_ACCEPT, 32'h1, "post_reset_issue0");

        for (int i = 0; i < 10 && sbQueue.size() > 0; i++) begin
            @(posedge clock);
        end
        if (sbQueue.size() > 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", sbQueue.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
